draw_sprites: RTL and testbench

DRAW_SPRITES -- requirements
Module: draw_sprites

---
 rtl/draw_sprites.sv | 135 +++++++++++++
 tb/tb_draw_sprites.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprites.sv
// Sprite compositor: N_SPR ROM-backed sprites overlaid on a video stream.
// Three-stage pipeline aligned to a synchronous external sprite ROM.
module draw_sprites #(
    parameter int          N_SPR = 4,
    parameter int          SPR_W = 128,
    parameter int          SPR_H = 128,
    parameter int          AW    = 14,
    parameter logic [11:0] KEY   = 12'hF0F
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic [10:0]         hcount_in,
    input  logic [10:0]         vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                hblnk_in,
    input  logic                vblnk_in,
    input  logic [11:0]         rgb_in,
    input  logic [11*N_SPR-1:0] xpos,
    input  logic [11*N_SPR-1:0] ypos,
    input  logic [N_SPR-1:0]    spr_en,
    input  logic [N_SPR-1:0]    flip_h,
    input  logic [12*N_SPR-1:0] rgb_pixel,
    output logic [AW*N_SPR-1:0] pixel_addr,
    output logic [10:0]         hcount_out,
    output logic [10:0]         vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                hblnk_out,
    output logic                vblnk_out,
    output logic [11:0]         rgb_out,
    output logic                frame_start
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int TW = 26;

    logic [11*N_SPR-1:0] sh_x, sh_y, eff_x, eff_y;
    logic [N_SPR-1:0]    sh_en, sh_fl, eff_en, eff_fl;
    logic [N_SPR-1:0]    hit_c, hit_d1, hit_d2;
    logic [AW*N_SPR-1:0] addr_c;
    logic [11:0]         rgb_d1, rgb_d2, rgb_c;
    logic [TW-1:0]       tim_in, tim_d1, tim_d2, tim_d3;
    logic                load, vld_d1, vld_d2;

    assign load = (hcount_in == 11'd0) && (vcount_in == 11'd0);

    // The frame origin pixel already sees the freshly loaded values
    assign eff_x  = load ? xpos   : sh_x;
    assign eff_y  = load ? ypos   : sh_y;
    assign eff_en = load ? spr_en : sh_en;
    assign eff_fl = load ? flip_h : sh_fl;

    assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in,
                     hblnk_in, vblnk_in};

    genvar g;
    for (g = 0; g < N_SPR; g++) begin : g_spr
        logic [11:0]   x12, y12, h12, v12;
        logic [XW-1:0] dx, lx;
        logic [YW-1:0] dy;
        logic          in_x, in_y;

        assign x12 = {1'b0, eff_x[11*g +: 11]};
        assign y12 = {1'b0, eff_y[11*g +: 11]};
        assign h12 = {1'b0, hcount_in};
        assign v12 = {1'b0, vcount_in};
        // 12-bit bounds keep origins near 2047 from wrapping to column 0
        assign in_x = (h12 >= x12) && (h12 < x12 + 12'(SPR_W));
        assign in_y = (v12 >= y12) && (v12 < y12 + 12'(SPR_H));
        assign dx = hcount_in[XW-1:0] - eff_x[11*g +: XW];
        assign dy = vcount_in[YW-1:0] - eff_y[11*g +: YW];
        assign lx = eff_fl[g] ? ~dx : dx;
        assign hit_c[g] = eff_en[g] && !hblnk_in && !vblnk_in
                          && in_x && in_y;
        assign addr_c[AW*g +: AW] = hit_c[g] ? AW'({dy, lx}) : '0;
    end

    // Walk from the lowest priority up so sprite 0 wins
    always_comb begin
        rgb_c = rgb_d2;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_d2[i] && (rgb_pixel[12*i +: 12] != KEY))
                rgb_c = rgb_pixel[12*i +: 12];
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_en <= '0;
            sh_fl <= '0;
        end else if (load) begin
            sh_x  <= xpos;
            sh_y  <= ypos;
            sh_en <= spr_en;
            sh_fl <= flip_h;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr  <= '0;
            hit_d1      <= '0;
            hit_d2      <= '0;
            rgb_d1      <= '0;
            rgb_d2      <= '0;
            rgb_out     <= '0;
            tim_d1      <= '0;
            tim_d2      <= '0;
            tim_d3      <= '0;
            vld_d1      <= 1'b0;
            vld_d2      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_addr  <= addr_c;
            hit_d1      <= hit_c;
            hit_d2      <= hit_d1;
            rgb_d1      <= rgb_in;
            rgb_d2      <= rgb_d1;
            rgb_out     <= rgb_c;
            tim_d1      <= tim_in;
            tim_d2      <= tim_d1;
            tim_d3      <= tim_d2;
            vld_d1      <= 1'b1;
            vld_d2      <= vld_d1;
            frame_start <= vld_d2 && (tim_d2[25:4] == 22'd0);
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out,
            hblnk_out, vblnk_out} = tim_d3;

endmodule

// File: tb/tb_draw_sprites.sv
// Scoreboard bench for draw_sprites: randomized raster segments checked
// against a per-pixel reference model and a synchronous ROM model.
module tb_draw_sprites;
    localparam int          N   = 4;
    localparam int          W   = 128;
    localparam int          H   = 128;
    localparam int          AW  = 14;
    localparam logic [11:0] KEY = 12'hF0F;

    logic            pclk;
    logic            rst_n;
    logic [10:0]     hcount_in, vcount_in;
    logic            hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0]     rgb_in;
    logic [11*N-1:0] xpos, ypos;
    logic [N-1:0]    spr_en, flip_h;
    logic [12*N-1:0] rgb_pixel;
    logic [AW*N-1:0] pixel_addr;
    logic [10:0]     hcount_out, vcount_out;
    logic            hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0]     rgb_out;
    logic            frame_start;

    draw_sprites #(.N_SPR(N), .SPR_W(W), .SPR_H(H), .AW(AW), .KEY(KEY)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .spr_en(spr_en), .flip_h(flip_h), .rgb_pixel(rgb_pixel),
        .pixel_addr(pixel_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .frame_start(frame_start)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int rom_mode = 0;

    typedef struct { int due; logic [AW*N-1:0] a; } ea_t;
    typedef struct { int due; logic [11:0] rgb; logic [25:0] tim; logic fs; } eo_t;
    ea_t qa[$];
    eo_t qo[$];

    int in_x[N], in_y[N];
    bit in_en[N], in_fl[N];
    int mx[N], my[N];
    bit men[N], mfl[N];

    function automatic logic [11:0] rom(int i, int a);
        if (rom_mode == 1) begin
            if (i == 0) return (a % 2 == 0) ? KEY : 12'h123;
            return 12'hABC;
        end
        if ((a % 7) == i) return KEY;
        return 12'((a * 37 + i * 1111 + 5) & 'hFFF);
    endfunction

    always @(posedge pclk)
        for (int i = 0; i < N; i++)
            rgb_pixel[12*i +: 12] <= rom(i, int'(pixel_addr[AW*i +: AW]));

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endfunction

    always @(negedge pclk) begin
        ea_t ea;
        eo_t eo;
        if (qa.size() != 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            chk("pixel_addr", 64'(pixel_addr), 64'(ea.a));
        end
        if (qo.size() != 0 && qo[0].due == cyc) begin
            eo = qo.pop_front();
            chk("rgb_out", 64'(rgb_out), 64'(eo.rgb));
            chk("timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                               hblnk_out, vblnk_out}), 64'(eo.tim));
            chk("frame_start", 64'(frame_start), 64'(eo.fs));
        end
    end

    task automatic setspr(int i, int x, int y, bit en, bit fl);
        in_x[i] = x; in_y[i] = y; in_en[i] = en; in_fl[i] = fl;
    endtask

    task automatic px(int h, int v, bit hb, bit vb, logic [11:0] bg);
        ea_t ea;
        eo_t eo;
        logic [11:0] pix;
        bit found;
        @(posedge pclk);
        #1;
        for (int i = 0; i < N; i++) begin
            xpos[11*i +: 11] = 11'(in_x[i]);
            ypos[11*i +: 11] = 11'(in_y[i]);
            spr_en[i] = in_en[i];
            flip_h[i] = in_fl[i];
        end
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
        hblnk_in = hb;
        vblnk_in = vb;
        rgb_in = bg;
        if (h == 0 && v == 0)
            for (int i = 0; i < N; i++) begin
                mx[i] = in_x[i]; my[i] = in_y[i];
                men[i] = in_en[i]; mfl[i] = in_fl[i];
            end
        ea.due = cyc + 1;
        ea.a = '0;
        pix = bg;
        found = 0;
        for (int i = 0; i < N; i++) begin
            int lx, ly, a;
            if (men[i] && !hb && !vb && h >= mx[i] && h < mx[i] + W
                && v >= my[i] && v < my[i] + H) begin
                lx = h - mx[i];
                if (mfl[i]) lx = W - 1 - lx;
                ly = v - my[i];
                a = ly * W + lx;
                ea.a[AW*i +: AW] = AW'(a);
                if (!found && rom(i, a) != KEY) begin
                    pix = rom(i, a);
                    found = 1;
                end
            end
        end
        eo.due = cyc + 3;
        eo.rgb = pix;
        eo.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hb, vb};
        eo.fs = (h == 0 && v == 0);
        qa.push_back(ea);
        qo.push_back(eo);
    endtask

    task automatic scan(int v, int h0, int h1, logic [11:0] bg);
        for (int h = h0; h <= h1; h++) px(h, v, 0, 0, bg);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge pclk);
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_rgb"}, 64'(rgb_out), 64'd0);
        chk({nm, "_addr"}, 64'(pixel_addr), 64'd0);
        chk({nm, "_tim"}, 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                               hblnk_out, vblnk_out}), 64'd0);
        chk({nm, "_fs"}, 64'(frame_start), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge pclk);
        #1;
        rst_n = 1'b0;
        hcount_in = 11'd1;
        vcount_in = 11'd1;
        qa.delete();
        qo.delete();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; men[i] = 0; mfl[i] = 0;
        end
        #1;
        check_zero("mid_reset");
        @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
    endtask

    task automatic clear_spr();
        for (int i = 0; i < N; i++) setspr(i, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        hcount_in = 11'd1; vcount_in = 11'd1;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        rgb_in = '0; xpos = '0; ypos = '0; spr_en = '0; flip_h = '0;
        clear_spr();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; men[i] = 0; mfl[i] = 0;
        end
        repeat (2) @(posedge pclk);
        #1;
        check_zero("init_reset");
        @(negedge pclk);
        rst_n = 1'b1;

        // enabled at the inputs but not yet loaded: background only
        setspr(0, 100, 50, 1, 0);
        scan(50, 95, 110, 12'h00F);

        px(0, 0, 0, 0, 12'h00F);
        scan(49, 98, 102, 12'h00F);
        scan(50, 95, 230, 12'h00F);
        scan(177, 95, 105, 12'h00F);
        scan(178, 95, 105, 12'h00F);

        // overlap with fixed ROM contents
        idle(4);
        rom_mode = 1;
        idle(4);
        setspr(1, 110, 60, 1, 0);
        px(0, 0, 0, 0, 12'h0F0);
        scan(70, 100, 250, 12'h0F0);
        idle(4);
        rom_mode = 0;
        idle(4);

        // mid-frame position change is held off until next frame
        clear_spr();
        setspr(0, 100, 150, 1, 0);
        px(0, 0, 0, 0, 12'h00F);
        scan(200, 90, 240, 12'h00F);
        setspr(0, 300, 150, 1, 0);
        scan(201, 90, 440, 12'h00F);
        scan(250, 90, 440, 12'h00F);
        px(0, 0, 0, 0, 12'h00F);
        scan(160, 90, 440, 12'h00F);

        // horizontal mirror at the left edge
        setspr(0, 0, 5, 1, 1);
        px(0, 0, 0, 0, 12'h00F);
        scan(5, 0, 130, 12'h00F);

        // clipping at the right edge, no wrap into column 0
        setspr(0, 2000, 20, 1, 0);
        px(0, 0, 0, 0, 12'h00F);
        scan(20, 1990, 2047, 12'h00F);
        scan(20, 0, 90, 12'h00F);

        // reset in the middle of a sprite
        setspr(0, 100, 50, 1, 0);
        px(0, 0, 0, 0, 12'h0AA);
        scan(60, 95, 140, 12'h0AA);
        do_reset();
        scan(60, 100, 160, 12'h0AA);
        px(0, 0, 0, 0, 12'h0AA);
        scan(60, 100, 160, 12'h0AA);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++)
                setspr(i,
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(1900, 2047))
                                                   : int'($urandom_range(0, 300)),
                       int'($urandom_range(0, 300)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            px(0, 0, 0, 0, 12'($urandom));
            for (int s = 0; s < 6; s++) begin
                int v, h0, len;
                v = int'($urandom_range(0, 420));
                h0 = int'($urandom_range(1, 400));
                len = int'($urandom_range(20, 120));
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 1) == 1)
                        setspr(i, int'($urandom_range(0, 2047)),
                               int'($urandom_range(0, 2047)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                for (int h = h0; h < h0 + len; h++)
                    px(h, v, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 31) == 0, 12'($urandom));
            end
        end

        idle(6);
        #1;
        chk("drain", 64'(qa.size() + qo.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
